// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared read-mode constants and width helper for the parametrised FIFO
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - WIDTH x DEPTH register array, one synchronous write port, one asynchronous read port
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with occupancy, almost flags, sticky errors and optional FWFT read
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 8,
    parameter  int AF_THRESH = 6,
    parameter  int AE_THRESH = 1,
    parameter  int FWFT      = FIFO_MODE_STD,
    localparam int PW        = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CW        = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count_o,
    output logic             overflow_o,
    output logic             underflow_o,
    input  logic             err_clr_i
);

    if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_params
        $error("sync_fifo_param: illegal DEPTH/AF_THRESH/AE_THRESH");
    end

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_mem_rd;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full         = (r_count == CW'(DEPTH));
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= CW'(AF_THRESH));
    assign almost_empty = (r_count <= CW'(AE_THRESH));
    assign count_o      = r_count;
    assign overflow_o   = r_overflow;
    assign underflow_o  = r_underflow;

    // Acceptance uses start-of-cycle state, so a write while full is dropped even alongside a read.
    assign w_wr_acc = wr_en_i & ~full;
    assign w_rd_acc = rd_en_i & ~empty;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow  <= (wr_en_i & full)  | (r_overflow  & ~err_clr_i);
            r_underflow <= (rd_en_i & empty) | (r_underflow & ~err_clr_i);
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .i_clk     (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_i),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rd)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign data_o  = w_mem_rd;
        assign valid_o = ~empty;
    end else begin : g_std
        logic [WIDTH-1:0] r_data;
        logic             r_valid;

        always_ff @(posedge clk) begin
            if (rst_i) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_data <= w_mem_rd;
                end
            end
        end

        assign data_o  = r_data;
        assign valid_o = r_valid;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param in standard and FWFT modes
module tb_sync_fifo_param;

    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       s_wr = 1'b0, s_rd = 1'b0, s_clr = 1'b0;
    logic [7:0] s_din = 8'h00;
    logic [7:0] s_dout;
    logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [3:0] s_cnt;

    logic       f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
    logic [7:0] f_din = 8'h00;
    logic [7:0] f_dout;
    logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0] f_cnt;

    int n_cmp = 0;
    int n_err = 0;

    initial forever #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
        .clk(clk), .rst_i(rst), .wr_en_i(s_wr), .data_i(s_din), .rd_en_i(s_rd),
        .data_o(s_dout), .valid_o(s_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count_o(s_cnt),
        .overflow_o(s_ovf), .underflow_o(s_udf), .err_clr_i(s_clr)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst_i(rst), .wr_en_i(f_wr), .data_i(f_din), .rd_en_i(f_rd),
        .data_o(f_dout), .valid_o(f_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count_o(f_cnt),
        .overflow_o(f_ovf), .underflow_o(f_udf), .err_clr_i(f_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: queue per instance, updated with the inputs present at each rising edge.
    bit         m_started = 1'b0;
    logic [7:0] sq[$];
    logic [7:0] fq[$];
    logic [7:0] ms_data = 8'h00;
    bit         ms_valid, ms_ovf, ms_udf, mf_ovf, mf_udf;
    bit         m_full, m_empty;

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1'b1;
            sq.delete();
            fq.delete();
            ms_data  = 8'h00;
            ms_valid = 1'b0;
            ms_ovf   = 1'b0;
            ms_udf   = 1'b0;
            mf_ovf   = 1'b0;
            mf_udf   = 1'b0;
        end else if (m_started) begin
            m_full  = (sq.size() == D);
            m_empty = (sq.size() == 0);
            ms_ovf  = (s_wr && m_full)  || (ms_ovf && !s_clr);
            ms_udf  = (s_rd && m_empty) || (ms_udf && !s_clr);
            ms_valid = 1'b0;
            if (s_rd && !m_empty) begin
                ms_data  = sq.pop_front();
                ms_valid = 1'b1;
            end
            if (s_wr && !m_full) sq.push_back(s_din);

            m_full  = (fq.size() == D);
            m_empty = (fq.size() == 0);
            mf_ovf  = (f_wr && m_full)  || (mf_ovf && !f_clr);
            mf_udf  = (f_rd && m_empty) || (mf_udf && !f_clr);
            if (f_rd && !m_empty) void'(fq.pop_front());
            if (f_wr && !m_full) fq.push_back(f_din);
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("s_count", 32'(s_cnt),   32'(sq.size()));
            chk("s_full",  32'(s_full),  32'(sq.size() == D));
            chk("s_empty", 32'(s_empty), 32'(sq.size() == 0));
            chk("s_af",    32'(s_af),    32'(sq.size() >= AF));
            chk("s_ae",    32'(s_ae),    32'(sq.size() <= AE));
            chk("s_ovf",   32'(s_ovf),   32'(ms_ovf));
            chk("s_udf",   32'(s_udf),   32'(ms_udf));
            chk("s_valid", 32'(s_valid), 32'(ms_valid));
            chk("s_data",  32'(s_dout),  32'(ms_data));
            chk("f_count", 32'(f_cnt),   32'(fq.size()));
            chk("f_full",  32'(f_full),  32'(fq.size() == D));
            chk("f_empty", 32'(f_empty), 32'(fq.size() == 0));
            chk("f_af",    32'(f_af),    32'(fq.size() >= AF));
            chk("f_ae",    32'(f_ae),    32'(fq.size() <= AE));
            chk("f_ovf",   32'(f_ovf),   32'(mf_ovf));
            chk("f_udf",   32'(f_udf),   32'(mf_udf));
            chk("f_valid", 32'(f_valid), 32'(fq.size() != 0));
            if (fq.size() != 0) chk("f_data", 32'(f_dout), 32'(fq[0]));
        end
    end

    task automatic step_s(input bit wr, input bit rd, input logic [7:0] d, input bit clr);
        s_wr = wr; s_rd = rd; s_din = d; s_clr = clr;
        @(negedge clk);
        s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0;
    endtask

    task automatic step_f(input bit wr, input bit rd, input logic [7:0] d);
        f_wr = wr; f_rd = rd; f_din = d;
        @(negedge clk);
        f_wr = 1'b0; f_rd = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_count", 32'(s_cnt), 32'd0);
        chk("rst_empty", 32'(s_empty), 32'd1);
        chk("rst_ae", 32'(s_ae), 32'd1);
        chk("rst_full", 32'(s_full), 32'd0);
        chk("rst_af", 32'(s_af), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_data", 32'(s_dout), 32'h00);

        for (int i = 0; i < 8; i++) begin
            step_s(1, 0, 8'(i), 0);
            chk("t1_count", 32'(s_cnt), 32'(i + 1));
            chk("t1_ae", 32'(s_ae), 32'(i == 0));
            chk("t1_af", 32'(s_af), 32'(i >= 5));
        end
        chk("t1_full", 32'(s_full), 32'd1);
        step_s(1, 0, 8'hAA, 0);
        chk("t1_ovf", 32'(s_ovf), 32'd1);
        chk("t1_count9", 32'(s_cnt), 32'd8);

        for (int i = 0; i < 8; i++) begin
            step_s(0, 1, 8'h00, 0);
            chk("t2_data", 32'(s_dout), 32'(i));
            chk("t2_valid", 32'(s_valid), 32'd1);
        end
        chk("t2_empty", 32'(s_empty), 32'd1);
        step_s(0, 1, 8'h00, 0);
        chk("t2_udf", 32'(s_udf), 32'd1);
        chk("t2_valid9", 32'(s_valid), 32'd0);
        chk("t2_hold", 32'(s_dout), 32'h07);
        step_s(0, 0, 8'h00, 1);

        for (int i = 0; i < 5; i++) step_s(1, 0, 8'(8'h05 + i), 0);
        for (int i = 0; i < 5; i++) begin
            step_s(0, 1, 8'h00, 0);
            chk("t3_pre", 32'(s_dout), 32'(8'h05 + i));
        end
        for (int i = 0; i < 8; i++) step_s(1, 0, 8'(8'h10 + i), 0);
        chk("t3_full", 32'(s_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step_s(0, 1, 8'h00, 0);
            chk("t3_wrap", 32'(s_dout), 32'(8'h10 + i));
        end

        for (int i = 0; i < 3; i++) step_s(1, 0, 8'(8'h20 + i), 0);
        for (int i = 0; i < 4; i++) begin
            step_s(1, 1, 8'(8'h30 + i), 0);
            chk("t4_cnt3", 32'(s_cnt), 32'd3);
            chk("t4_order", 32'(s_dout), (i < 3) ? 32'(8'h20 + i) : 32'h30);
        end
        for (int i = 1; i < 4; i++) begin
            step_s(0, 1, 8'h00, 0);
            chk("t4_drain", 32'(s_dout), 32'(8'h30 + i));
        end
        for (int i = 0; i < 8; i++) step_s(1, 0, 8'(8'h40 + i), 0);
        step_s(1, 1, 8'h50, 0);
        chk("t4_full_rw_cnt", 32'(s_cnt), 32'd7);
        chk("t4_full_rw_ovf", 32'(s_ovf), 32'd1);
        chk("t4_full_rw_data", 32'(s_dout), 32'h40);
        for (int i = 1; i < 8; i++) begin
            step_s(0, 1, 8'h00, 0);
            chk("t4_drain2", 32'(s_dout), 32'(8'h40 + i));
        end
        step_s(1, 1, 8'h60, 0);
        chk("t4_empty_rw_cnt", 32'(s_cnt), 32'd1);
        chk("t4_empty_rw_udf", 32'(s_udf), 32'd1);
        chk("t4_empty_rw_valid", 32'(s_valid), 32'd0);
        step_s(0, 0, 8'h00, 1);
        chk("t4_clr_ovf", 32'(s_ovf), 32'd0);
        chk("t4_clr_udf", 32'(s_udf), 32'd0);
        for (int i = 1; i < 8; i++) step_s(1, 0, 8'(8'h60 + i), 0);
        step_s(1, 0, 8'h70, 1);
        chk("t4_set_wins", 32'(s_ovf), 32'd1);
        chk("t4_set_cnt", 32'(s_cnt), 32'd8);

        step_f(1, 0, 8'h3C);
        chk("t5_empty", 32'(f_empty), 32'd0);
        chk("t5_valid", 32'(f_valid), 32'd1);
        chk("t5_data", 32'(f_dout), 32'h3C);
        step_f(0, 1, 8'h00);
        chk("t5_pop_valid", 32'(f_valid), 32'd0);
        step_f(1, 0, 8'h01);
        step_f(1, 0, 8'h02);
        chk("t5_head", 32'(f_dout), 32'h01);
        step_f(0, 1, 8'h00);
        chk("t5_next", 32'(f_dout), 32'h02);
        chk("t5_next_valid", 32'(f_valid), 32'd1);

        for (int i = 0; i < 3; i++) begin
            step_s(0, 1, 8'h00, 0);
            chk("t6_pre", 32'(s_dout), 32'(8'h60 + i));
        end
        chk("t6_cnt5", 32'(s_cnt), 32'd5);
        chk("t6_ovf_pre", 32'(s_ovf), 32'd1);
        rst = 1'b1; s_wr = 1'b1; s_din = 8'h99;
        @(negedge clk);
        rst = 1'b0; s_wr = 1'b0;
        chk("t6_count", 32'(s_cnt), 32'd0);
        chk("t6_empty", 32'(s_empty), 32'd1);
        chk("t6_ae", 32'(s_ae), 32'd1);
        chk("t6_ovf", 32'(s_ovf), 32'd0);
        chk("t6_valid", 32'(s_valid), 32'd0);
        chk("t6_data", 32'(s_dout), 32'h00);
        repeat (2) @(negedge clk);
        chk("t6_write_ignored", 32'(s_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
